// File: rtl/spi_master_arbiter_if.sv
// Signal bundle for spi_master_arbiter: requester handshake, tagged responses,
// per-slave chip selects and the shared spi_master byte-engine handshake.
interface spi_master_arbiter_if #(
    parameter int unsigned N_REQ = 4
) ();
    localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic               rsp_valid;
    logic [7:0]         rsp_data;
    logic [IDW-1:0]     rsp_id;
    logic               rsp_abort;
    logic               busy;
    logic [N_REQ-1:0]   cs_n;
    logic               m_start;
    logic [7:0]         m_data_in;
    logic [7:0]         m_data_out;
    logic               m_done;

    modport master (
        input  req_valid, req_data, req_last, m_data_out, m_done,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_abort, busy, cs_n,
               m_start, m_data_in
    );

    modport slave (
        output req_valid, req_data, req_last, m_data_out, m_done,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_abort, busy, cs_n,
               m_start, m_data_in
    );
endinterface

// File: rtl/spi_master_arbiter.sv
// Round-robin scheduler sharing one spi_master byte engine between N_REQ requesters,
// owning per-slave chip selects for whole bursts with CS setup, deselect gap and hold timeout.
module spi_master_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_GAP   = 4,
    parameter int unsigned HOLD_MAX = 255
) (
    input logic                  clk,
    input logic                  rst_n,
    spi_master_arbiter_if.master bus
);
    localparam int unsigned    IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [15:0]    SetupLoad = 16'(CS_SETUP);
    localparam logic [15:0]    GapLoad   = 16'(CS_GAP);
    localparam logic [15:0]    HoldLast  = 16'(HOLD_MAX - 1);
    localparam logic [IDW-1:0] PtrRst    = IDW'(N_REQ - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StLaunch, StWait, StHold, StGap} state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic               last_q, last_d;
    logic [15:0]        cnt_q, cnt_d;

    logic [N_REQ-1:0]   req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [7:0]         rsp_data_q, rsp_data_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic               rsp_abort_q, rsp_abort_d;
    logic               busy_q, busy_d;
    logic [N_REQ-1:0]   cs_n_q, cs_n_d;
    logic               m_start_q, m_start_d;
    logic [7:0]         m_data_in_q, m_data_in_d;

    logic               grant_found;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     cand;

    // Search starts just above the last served requester and wraps modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = IDW'((32'(ptr_q) + i) % N_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_abort_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        unique case (state_q)
            StIdle: begin
                if (grant_found) begin
                    id_d    = grant_id;
                    cnt_d   = SetupLoad;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q <= 16'd1) begin
                    state_d = StLaunch;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StLaunch: begin
                last_d  = bus.req_last[id_q];
                state_d = StWait;
            end
            StWait: begin
                if (bus.m_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.m_data_out;
                    rsp_id_d    = id_q;
                    if (last_q) begin
                        ptr_d   = id_q;
                        cnt_d   = GapLoad;
                        state_d = StGap;
                    end else begin
                        cnt_d   = '0;
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (bus.req_valid[id_q]) begin
                    state_d = StLaunch;
                end else if (cnt_q >= HoldLast) begin
                    rsp_abort_d = 1'b1;
                    rsp_id_d    = id_q;
                    ptr_d       = id_q;
                    cnt_d       = GapLoad;
                    state_d     = StGap;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StGap: begin
                if (cnt_q <= 16'd1) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_comb begin
        req_ready_d = '0;
        m_start_d   = 1'b0;
        m_data_in_d = m_data_in_q;
        cs_n_d      = '1;
        busy_d      = (state_d != StIdle);
        if (state_d == StLaunch) begin
            req_ready_d[id_d] = 1'b1;
            m_start_d         = 1'b1;
            m_data_in_d       = bus.req_data[{id_d, 3'b000} +: 8];
        end
        if (state_d inside {StSetup, StLaunch, StWait, StHold}) begin
            cs_n_d[id_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            id_q        <= '0;
            ptr_q       <= PtrRst;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            req_ready_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_abort_q <= 1'b0;
            busy_q      <= 1'b0;
            cs_n_q      <= '1;
            m_start_q   <= 1'b0;
            m_data_in_q <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_abort_q <= rsp_abort_d;
            busy_q      <= busy_d;
            cs_n_q      <= cs_n_d;
            m_start_q   <= m_start_d;
            m_data_in_q <= m_data_in_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_abort = rsp_abort_q;
    assign bus.busy      = busy_q;
    assign bus.cs_n      = cs_n_q;
    assign bus.m_start   = m_start_q;
    assign bus.m_data_in = m_data_in_q;
endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: queued requesters, a fixed-latency slave engine
// and a negedge monitor that logs grants, starts, responses and aborts with cycle stamps.
module tb_spi_master_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_master_arbiter_if #(.N_REQ(N)) bus ();

    spi_master_arbiter #(
        .N_REQ   (N),
        .CS_SETUP(2),
        .CS_GAP  (4),
        .HOLD_MAX(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] rq_mem [N][16];
    int         rq_tail [N];
    int         rq_head [N];
    bit         pop_pending [N];
    logic [7:0] resp_xor;
    int         inject_req = 0, inject_ack = 0;
    int         clear_req = 0, clear_ack = 0;
    int         slave_cnt;
    logic [7:0] slave_byte;

    int         cyc, lows, gap_run, min_gap, overlap_err, cs0_low, busy_high_run, last_gap_len;
    bit         busy_prev;
    logic [N-1:0] prev_cs;
    int         ready_cnt [N];
    int         grant_log[$], fall_cyc[$], start_cyc[$], rsp_cyc[$], rsp_id_log[$];
    int         abort_cyc[$], abort_id_log[$];
    logic [7:0] start_data[$], rsp_data_log[$];
    logic [N-1:0] abort_cs[$];

    // Monitor, slave engine and requester queues all advance on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (clear_req != clear_ack) begin
            clear_ack = clear_req;
            grant_log.delete(); fall_cyc.delete(); start_cyc.delete(); start_data.delete();
            rsp_cyc.delete(); rsp_id_log.delete(); rsp_data_log.delete();
            abort_cyc.delete(); abort_id_log.delete(); abort_cs.delete();
            min_gap = 1000; overlap_err = 0; cs0_low = 0; last_gap_len = -1;
            for (int i = 0; i < N; i++) ready_cnt[i] = 0;
        end
        if (rst_n) begin
            lows = 0;
            for (int i = 0; i < N; i++) begin
                if (!bus.cs_n[i]) lows++;
                if (prev_cs[i] && !bus.cs_n[i]) begin
                    grant_log.push_back(i);
                    fall_cyc.push_back(cyc);
                    if (gap_run < min_gap) min_gap = gap_run;
                end
                if (bus.req_ready[i]) ready_cnt[i]++;
            end
            if (lows > 1) overlap_err++;
            if (&bus.cs_n) gap_run++; else gap_run = 0;
            if (bus.cs_n == 4'b1110) cs0_low++;
            if (bus.busy && (&bus.cs_n)) begin
                busy_high_run++;
            end else begin
                if (!bus.busy && busy_prev) last_gap_len = busy_high_run;
                busy_high_run = 0;
            end
            if (bus.m_start) begin
                start_cyc.push_back(cyc);
                start_data.push_back(bus.m_data_in);
            end
            if (bus.rsp_valid) begin
                rsp_cyc.push_back(cyc);
                rsp_id_log.push_back(int'(bus.rsp_id));
                rsp_data_log.push_back(bus.rsp_data);
            end
            if (bus.rsp_abort) begin
                abort_cyc.push_back(cyc);
                abort_id_log.push_back(int'(bus.rsp_id));
                abort_cs.push_back(bus.cs_n);
            end
        end else begin
            gap_run = 1000;
        end
        prev_cs   = bus.cs_n;
        busy_prev = bus.busy;

        bus.m_done = 1'b0;
        if (!rst_n) begin
            slave_cnt = 0;
        end else if (inject_req != inject_ack) begin
            inject_ack = inject_req;
            bus.m_done = 1'b1;
            bus.m_data_out = 8'hEE;
        end else if (slave_cnt != 0) begin
            slave_cnt--;
            if (slave_cnt == 0) begin
                bus.m_done = 1'b1;
                bus.m_data_out = slave_byte ^ resp_xor;
            end
        end
        if (rst_n && bus.m_start) begin
            slave_cnt = 3;
            slave_byte = bus.m_data_in;
        end

        // A byte is retired one half-cycle after its req_ready cycle has closed.
        for (int i = 0; i < N; i++) begin
            if (pop_pending[i]) begin
                rq_head[i]++;
                pop_pending[i] = 1'b0;
            end
            if (rst_n && bus.req_ready[i]) pop_pending[i] = 1'b1;
            bus.req_valid[i] = (rq_head[i] != rq_tail[i]);
            bus.req_data[8*i +: 8] = bus.req_valid[i] ? rq_mem[i][rq_head[i] % 16][7:0] : 8'h00;
            bus.req_last[i] = bus.req_valid[i] ? rq_mem[i][rq_head[i] % 16][8] : 1'b0;
        end
    end

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (rq_head[i] != rq_tail[i] || pop_pending[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push(input int id, input logic [7:0] data, input logic last);
        rq_mem[id][rq_tail[id] % 16] = {last, data};
        rq_tail[id]++;
    endtask

    task automatic clear_logs();
        clear_req++;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            if (!bus.busy && queues_empty() && slave_cnt == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        #1;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s_idle: got busy=%b, required idle within 400 cycles", tag, bus.busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.cs_n !== 4'b1111) begin
            miscompares++; $display("FAIL reset_cs_n: got %b, required 1111", bus.cs_n);
        end
        vectors++;
        if ({bus.busy, bus.m_start, bus.rsp_valid, bus.rsp_abort} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctl: got busy/start/rvalid/abort %b%b%b%b, required 0000",
                     bus.busy, bus.m_start, bus.rsp_valid, bus.rsp_abort);
        end
        vectors++;
        if ({bus.req_ready, bus.rsp_data, bus.rsp_id, bus.m_data_in} !== 22'd0) begin
            miscompares++;
            $display("FAIL reset_data: got ready=%b rsp=%h id=%0d mdi=%h, required all zero",
                     bus.req_ready, bus.rsp_data, bus.rsp_id, bus.m_data_in);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_release_busy: got %b, required 0", bus.busy);
        end
    endtask

    task automatic test_single();
        clear_logs();
        resp_xor = 8'h99;
        push(0, 8'hA5, 1'b1);
        wait_idle("single");
        vectors++;
        if (grant_log.size() != 1 || grant_log[0] != 0) begin
            miscompares++;
            $display("FAIL single_grant: got %0d grants first %0d, required 1 grant of 0",
                     grant_log.size(), grant_log.size() ? grant_log[0] : -1);
        end
        vectors++;
        if (start_data.size() != 1 || start_data[0] !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_start: got %0d starts, required one with a5", start_data.size());
        end else begin
            vectors++;
            if (start_cyc[0] - fall_cyc[0] != 2) begin
                miscompares++;
                $display("FAIL single_setup: got %0d cycles, required 2", start_cyc[0] - fall_cyc[0]);
            end
        end
        vectors++;
        if (rsp_data_log.size() != 1 || rsp_data_log[0] !== 8'h3C || rsp_id_log[0] != 0) begin
            miscompares++;
            $display("FAIL single_rsp: got %0d responses, required one 3c id 0", rsp_data_log.size());
        end else begin
            vectors++;
            if (rsp_cyc[0] - start_cyc[0] != 4) begin
                miscompares++;
                $display("FAIL single_rsp_lat: got %0d, required 4", rsp_cyc[0] - start_cyc[0]);
            end
        end
        vectors++;
        if (cs0_low != 6) begin
            miscompares++; $display("FAIL single_cs_1110: got %0d cycles, required 6", cs0_low);
        end
        vectors++;
        if (last_gap_len != 4) begin
            miscompares++; $display("FAIL single_gap: got %0d cycles, required 4", last_gap_len);
        end
        vectors++;
        if (ready_cnt[0] != 1) begin
            miscompares++; $display("FAIL single_ready: got %0d, required 1", ready_cnt[0]);
        end
    endtask

    task automatic test_contention();
        resp_xor = 8'h00;
        push(1, 8'h10, 1'b1);
        wait_idle("contention_warm");
        clear_logs();
        push(1, 8'h21, 1'b1);
        push(2, 8'h42, 1'b1);
        wait_idle("contention");
        vectors++;
        if (grant_log.size() != 2 || grant_log[0] != 2 || grant_log[1] != 1) begin
            miscompares++;
            $display("FAIL contention_order: got %0d grants, required order 2 then 1",
                     grant_log.size());
        end
        vectors++;
        if (overlap_err != 0) begin
            miscompares++; $display("FAIL contention_overlap: got %0d, required 0", overlap_err);
        end
        vectors++;
        if (min_gap < 4) begin
            miscompares++; $display("FAIL contention_gap: got %0d cycles, required >= 4", min_gap);
        end
        vectors++;
        if (rsp_data_log.size() != 2 || rsp_data_log[0] !== 8'h42 || rsp_data_log[1] !== 8'h21
            || rsp_id_log[0] != 2 || rsp_id_log[1] != 1) begin
            miscompares++;
            $display("FAIL contention_rsp: got %0d responses, required 42/id2 then 21/id1",
                     rsp_data_log.size());
        end
    endtask

    task automatic test_burst();
        clear_logs();
        resp_xor = 8'h0F;
        push(3, 8'h11, 1'b0);
        push(3, 8'h22, 1'b0);
        push(3, 8'h33, 1'b1);
        push(0, 8'h77, 1'b1);
        wait_idle("burst");
        vectors++;
        if (grant_log.size() != 2 || grant_log[0] != 3 || grant_log[1] != 0) begin
            miscompares++;
            $display("FAIL burst_grants: got %0d cs falls, required 3 once then 0", grant_log.size());
        end
        vectors++;
        if (ready_cnt[3] != 3) begin
            miscompares++; $display("FAIL burst_ready: got %0d, required 3", ready_cnt[3]);
        end
        vectors++;
        if (rsp_data_log.size() != 4 || rsp_data_log[0] !== 8'h1E || rsp_data_log[1] !== 8'h2D
            || rsp_data_log[2] !== 8'h3C || rsp_data_log[3] !== 8'h78) begin
            miscompares++;
            $display("FAIL burst_rsp_data: got %0d responses, required 1e 2d 3c 78",
                     rsp_data_log.size());
        end else begin
            vectors++;
            if (rsp_id_log[0] != 3 || rsp_id_log[1] != 3 || rsp_id_log[2] != 3 || rsp_id_log[3] != 0)
            begin
                miscompares++;
                $display("FAIL burst_rsp_id: got %0d %0d %0d %0d, required 3 3 3 0",
                         rsp_id_log[0], rsp_id_log[1], rsp_id_log[2], rsp_id_log[3]);
            end
        end
        vectors++;
        if (start_cyc.size() != 4 || start_cyc[1] - start_cyc[0] != 5
            || start_cyc[2] - start_cyc[1] != 5 || start_data[2] !== 8'h33) begin
            miscompares++;
            $display("FAIL burst_starts: got %0d starts, required spacing 5 and third byte 33",
                     start_cyc.size());
        end
        vectors++;
        if (overlap_err != 0) begin
            miscompares++; $display("FAIL burst_overlap: got %0d, required 0", overlap_err);
        end
    endtask

    task automatic test_hold_timeout();
        clear_logs();
        resp_xor = 8'h00;
        push(0, 8'h5A, 1'b0);
        wait_idle("hold");
        vectors++;
        if (abort_id_log.size() != 1 || abort_id_log[0] != 0) begin
            miscompares++;
            $display("FAIL hold_abort: got %0d aborts, required one with id 0", abort_id_log.size());
        end else begin
            vectors++;
            if (rsp_cyc.size() != 1 || abort_cyc[0] - rsp_cyc[0] != 8) begin
                miscompares++;
                $display("FAIL hold_time: got %0d cycles, required 8",
                         rsp_cyc.size() ? abort_cyc[0] - rsp_cyc[0] : -1);
            end
            vectors++;
            if (abort_cs[0] !== 4'b1111) begin
                miscompares++; $display("FAIL hold_cs: got %b, required 1111", abort_cs[0]);
            end
        end
        vectors++;
        if (rsp_data_log.size() != 1 || rsp_data_log[0] !== 8'h5A) begin
            miscompares++;
            $display("FAIL hold_rsp: got %0d responses, required one 5a", rsp_data_log.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_logs();
        resp_xor = 8'h00;
        push(0, 8'h99, 1'b1);
        push(1, 8'h88, 1'b1);
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (bus.m_start) begin
                ok = 1'b1;
                break;
            end
        end
        vectors++;
        if (!ok) begin
            miscompares++; $display("FAIL rstmid_start: got no m_start, required one within 50");
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.cs_n !== 4'b1101) begin
            miscompares++; $display("FAIL rstmid_wait_cs: got %b, required 1101", bus.cs_n);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.cs_n !== 4'b1111) begin
            miscompares++; $display("FAIL rstmid_async_cs: got %b, required 1111", bus.cs_n);
        end
        vectors++;
        if ({bus.m_start, bus.rsp_valid, bus.busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL rstmid_ctl: got start/rvalid/busy %b%b%b, required 000",
                     bus.m_start, bus.rsp_valid, bus.busy);
        end
        clear_logs();
        push(1, 8'h88, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_idle("rstmid");
        vectors++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1) begin
            miscompares++;
            $display("FAIL rstmid_priority: got %0d grants, required 0 then 1", grant_log.size());
        end
        vectors++;
        if (rsp_data_log.size() != 2 || rsp_data_log[0] !== 8'h99 || rsp_data_log[1] !== 8'h88) begin
            miscompares++;
            $display("FAIL rstmid_rsp: got %0d responses, required 99 then 88", rsp_data_log.size());
        end
    endtask

    task automatic test_stray_done();
        clear_logs();
        inject_req++;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (rsp_cyc.size() != 0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_done: got %0d responses busy=%b, required 0 and 0",
                     rsp_cyc.size(), bus.busy);
        end
    endtask

    task automatic test_wrap();
        resp_xor = 8'h00;
        push(3, 8'h30, 1'b1);
        wait_idle("wrap_warm");
        clear_logs();
        push(0, 8'h01, 1'b1);
        push(3, 8'h03, 1'b1);
        wait_idle("wrap");
        vectors++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 3) begin
            miscompares++;
            $display("FAIL wrap_order: got %0d grants first %0d, required 0 then 3",
                     grant_log.size(), grant_log.size() ? grant_log[0] : -1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200us, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resp_xor = 8'h00;
        test_reset();
        test_single();
        test_contention();
        test_burst();
        test_hold_timeout();
        test_reset_mid();
        test_stray_done();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
